// File: rtl/alu_rs.sv
// alu_rs: reservation station in front of the integer ALU.
// Holds issued ALU micro-ops until both operands are known, snoops the CDB
// for missing operands, dispatches the lowest-index ready entry each enabled
// cycle into registered ALU operand/opcode outputs, and registers the ALU
// result with its destination tag one cycle after dispatch.
module alu_rs #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             flush_in,
    input  logic             issue_valid,
    input  logic [3:0]       issue_op,
    input  logic [31:0]      issue_vj,
    input  logic [31:0]      issue_vk,
    input  logic             issue_qj_busy,
    input  logic             issue_qk_busy,
    input  logic [TAG_W-1:0] issue_qj,
    input  logic [TAG_W-1:0] issue_qk,
    input  logic [TAG_W-1:0] issue_dest,
    output logic             rs_full,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_value,
    output logic [31:0]      alu_op1,
    output logic [31:0]      alu_op2,
    output logic [3:0]       alu_op,
    input  logic [31:0]      alu_result,
    output logic             result_valid,
    output logic [TAG_W-1:0] result_tag,
    output logic [31:0]      result_value
);

    // DEPTH is a power of two and at least 2, so IDX_W is never zero.
    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic             busy;
        logic [3:0]       op;
        logic [31:0]      vj;
        logic [31:0]      vk;
        logic             qj_busy;
        logic [TAG_W-1:0] qj;
        logic             qk_busy;
        logic [TAG_W-1:0] qk;
        logic [TAG_W-1:0] dest;
    } entry_t;

    // Read-only view of every entry, used by the selectors and dispatch mux.
    entry_t             ent_vec [DEPTH];
    logic [DEPTH-1:0]   busy_vec;
    logic [DEPTH-1:0]   ready_vec;

    // Global event qualifiers.
    logic               active;      // enabled and not flushing
    logic               do_flush;    // enabled flush
    logic               issue_fire;
    logic               disp_fire;

    // Selector outputs.
    logic [IDX_W-1:0]   free_idx;
    logic               free_found;
    logic [IDX_W-1:0]   disp_idx;
    logic               disp_found;
    entry_t             disp_ent;

    // Incoming micro-op after same-cycle CDB forwarding.
    logic               fwd_j;
    logic               fwd_k;
    logic [31:0]        in_vj;
    logic [31:0]        in_vk;
    logic               in_qj_busy;
    logic               in_qk_busy;

    // Dispatch stage and output registers.
    logic               stage_valid_q, stage_valid_d;
    logic [TAG_W-1:0]   stage_dest_q,  stage_dest_d;
    logic [31:0]        alu_op1_q,     alu_op1_d;
    logic [31:0]        alu_op2_q,     alu_op2_d;
    logic [3:0]         alu_op_q,      alu_op_d;
    logic               result_valid_q, result_valid_d;
    logic [TAG_W-1:0]   result_tag_q,  result_tag_d;
    logic [31:0]        result_value_q, result_value_d;

    assign do_flush = rdy_in & flush_in;
    assign active   = rdy_in & ~flush_in;

    // Full is taken purely from registered busy bits.
    assign rs_full  = &busy_vec;

    // Issue is accepted only when a free slot exists in pre-edge state;
    // the dispatched entry is busy pre-edge, so the two never collide.
    assign issue_fire = active & issue_valid & ~rs_full & free_found;
    assign disp_fire  = active & disp_found;

    // Same-cycle forwarding of a CDB broadcast into the issuing micro-op.
    always_comb begin
        fwd_j      = issue_qj_busy & cdb_valid & (cdb_tag == issue_qj);
        fwd_k      = issue_qk_busy & cdb_valid & (cdb_tag == issue_qk);
        in_vj      = fwd_j ? cdb_value : issue_vj;
        in_vk      = fwd_k ? cdb_value : issue_vk;
        in_qj_busy = issue_qj_busy & ~fwd_j;
        in_qk_busy = issue_qk_busy & ~fwd_k;
    end

    // Lowest-index free entry (scan downwards so the last hit is the lowest).
    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy_vec[i]) begin
                free_idx   = IDX_W'(i);
                free_found = 1'b1;
            end
        end
    end

    // Lowest-index ready entry, from registered state only.
    always_comb begin
        disp_idx   = '0;
        disp_found = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready_vec[i]) begin
                disp_idx   = IDX_W'(i);
                disp_found = 1'b1;
            end
        end
    end

    assign disp_ent = ent_vec[disp_idx];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_entry
            entry_t ent_q;
            entry_t ent_d;

            assign ent_vec[gi]   = ent_q;
            assign busy_vec[gi]  = ent_q.busy;
            assign ready_vec[gi] = ent_q.busy & ~ent_q.qj_busy & ~ent_q.qk_busy;

            // Next state of one entry: flush, snoop, free on dispatch, load on issue.
            always_comb begin
                ent_d = ent_q;
                if (do_flush) begin
                    ent_d.busy = 1'b0;
                end else if (active) begin
                    if (ent_q.busy && ent_q.qj_busy && cdb_valid && (cdb_tag == ent_q.qj)) begin
                        ent_d.vj      = cdb_value;
                        ent_d.qj_busy = 1'b0;
                    end
                    if (ent_q.busy && ent_q.qk_busy && cdb_valid && (cdb_tag == ent_q.qk)) begin
                        ent_d.vk      = cdb_value;
                        ent_d.qk_busy = 1'b0;
                    end
                    if (disp_fire && (disp_idx == IDX_W'(gi))) begin
                        ent_d.busy = 1'b0;
                    end
                    if (issue_fire && (free_idx == IDX_W'(gi))) begin
                        ent_d.busy    = 1'b1;
                        ent_d.op      = issue_op;
                        ent_d.vj      = in_vj;
                        ent_d.vk      = in_vk;
                        ent_d.qj_busy = in_qj_busy;
                        ent_d.qj      = issue_qj;
                        ent_d.qk_busy = in_qk_busy;
                        ent_d.qk      = issue_qk;
                        ent_d.dest    = issue_dest;
                    end
                end
            end

            // Entry storage; reset empties the slot.
            always_ff @(posedge clk_in or negedge rst_in) begin
                if (!rst_in) begin
                    ent_q <= '0;
                end else begin
                    ent_q <= ent_d;
                end
            end
        end
    endgenerate

    // Dispatch stage and result register next state.
    always_comb begin
        stage_valid_d  = stage_valid_q;
        stage_dest_d   = stage_dest_q;
        alu_op1_d      = alu_op1_q;
        alu_op2_d      = alu_op2_q;
        alu_op_d       = alu_op_q;
        result_valid_d = 1'b0;
        result_tag_d   = result_tag_q;
        result_value_d = result_value_q;
        if (do_flush) begin
            stage_valid_d = 1'b0;
        end else if (active) begin
            // A micro-op sitting in the stage is retired on this edge.
            if (stage_valid_q) begin
                result_valid_d = 1'b1;
                result_tag_d   = stage_dest_q;
                result_value_d = alu_result;
            end
            stage_valid_d = disp_fire;
            if (disp_fire) begin
                stage_dest_d = disp_ent.dest;
                alu_op1_d    = disp_ent.vj;
                alu_op2_d    = disp_ent.vk;
                alu_op_d     = disp_ent.op;
            end
        end
    end

    // Dispatch stage, ALU operand and result registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            stage_valid_q  <= 1'b0;
            stage_dest_q   <= '0;
            alu_op1_q      <= '0;
            alu_op2_q      <= '0;
            alu_op_q       <= '0;
            result_valid_q <= 1'b0;
            result_tag_q   <= '0;
            result_value_q <= '0;
        end else begin
            stage_valid_q  <= stage_valid_d;
            stage_dest_q   <= stage_dest_d;
            alu_op1_q      <= alu_op1_d;
            alu_op2_q      <= alu_op2_d;
            alu_op_q       <= alu_op_d;
            result_valid_q <= result_valid_d;
            result_tag_q   <= result_tag_d;
            result_value_q <= result_value_d;
        end
    end

    assign alu_op1      = alu_op1_q;
    assign alu_op2      = alu_op2_q;
    assign alu_op       = alu_op_q;
    assign result_valid = result_valid_q;
    assign result_tag   = result_tag_q;
    assign result_value = result_value_q;

endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: scoreboard bench for alu_rs. A behavioural model of the station
// predicts, cycle by cycle, which result leaves on each edge; a separate
// monitor compares every DUT output against the queued predictions.
module tb_alu_rs;
    localparam int DEPTH = 8;
    localparam int TAG_W = 4;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic             rdy_in;
    logic             flush_in;
    logic             issue_valid;
    logic [3:0]       issue_op;
    logic [31:0]      issue_vj, issue_vk;
    logic             issue_qj_busy, issue_qk_busy;
    logic [TAG_W-1:0] issue_qj, issue_qk, issue_dest;
    logic             rs_full;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_value;
    logic [31:0]      alu_op1, alu_op2;
    logic [3:0]       alu_op;
    logic [31:0]      alu_result;
    logic             result_valid;
    logic [TAG_W-1:0] result_tag;
    logic [31:0]      result_value;

    always #5 clk_in = ~clk_in;

    alu_rs #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .issue_valid(issue_valid), .issue_op(issue_op),
        .issue_vj(issue_vj), .issue_vk(issue_vk),
        .issue_qj_busy(issue_qj_busy), .issue_qk_busy(issue_qk_busy),
        .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_dest(issue_dest),
        .rs_full(rs_full), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_op(alu_op), .alu_result(alu_result),
        .result_valid(result_valid), .result_tag(result_tag), .result_value(result_value)
    );

    // Reference ALU: 0 Add,1 Sub,2 Or,3 Xor,4 Lshift,5 Rshift,6 Lthan,7 Lequal,8 Rthan,9 Requal
    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a | b;
            4'd3: return a ^ b;
            4'd4: return a << b[4:0];
            4'd5: return a >> b[4:0];
            4'd6: return {31'b0, $signed(a) <  $signed(b)};
            4'd7: return {31'b0, $signed(a) <= $signed(b)};
            4'd8: return {31'b0, $signed(a) >  $signed(b)};
            4'd9: return {31'b0, $signed(a) >= $signed(b)};
            default: return 32'd0;
        endcase
    endfunction

    always_comb alu_result = alu_fn(alu_op, alu_op1, alu_op2);

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [31:0]      val;
    } res_t;

    res_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    logic exp_full = 1'b0;

    // Model state: pending micro-ops by slot, plus the op between dispatch and result.
    logic             m_busy [DEPTH];
    logic [3:0]       m_op   [DEPTH];
    logic [31:0]      m_vj   [DEPTH];
    logic [31:0]      m_vk   [DEPTH];
    logic             m_pj   [DEPTH];
    logic             m_pk   [DEPTH];
    logic [TAG_W-1:0] m_qj   [DEPTH];
    logic [TAG_W-1:0] m_qk   [DEPTH];
    logic [TAG_W-1:0] m_dest [DEPTH];
    logic             m_stg_v;
    res_t             m_stg;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
        m_stg_v  = 1'b0;
        exp_full = 1'b0;
        exp_q.delete();
    endtask

    // Advance the model across the next rising edge using the driven inputs.
    task automatic model_step();
        int d;
        int f;
        if (!rdy_in) return;
        if (flush_in) begin
            for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
            m_stg_v  = 1'b0;
            exp_full = 1'b0;
            return;
        end
        if (m_stg_v) exp_q.push_back(m_stg);
        d = -1;
        f = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (d < 0 && m_busy[i] && !m_pj[i] && !m_pk[i]) d = i;
            if (f < 0 && !m_busy[i]) f = i;
        end
        m_stg_v = (d >= 0);
        if (d >= 0) begin
            m_stg.tag = m_dest[d];
            m_stg.val = alu_fn(m_op[d], m_vj[d], m_vk[d]);
            m_busy[d] = 1'b0;
        end
        if (cdb_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (m_busy[i] && m_pj[i] && m_qj[i] == cdb_tag) begin m_vj[i] = cdb_value; m_pj[i] = 1'b0; end
                if (m_busy[i] && m_pk[i] && m_qk[i] == cdb_tag) begin m_vk[i] = cdb_value; m_pk[i] = 1'b0; end
            end
        end
        if (issue_valid && f >= 0) begin
            m_busy[f] = 1'b1;
            m_op[f]   = issue_op;
            m_dest[f] = issue_dest;
            m_qj[f]   = issue_qj;
            m_qk[f]   = issue_qk;
            m_pj[f]   = issue_qj_busy && !(cdb_valid && cdb_tag == issue_qj);
            m_pk[f]   = issue_qk_busy && !(cdb_valid && cdb_tag == issue_qk);
            m_vj[f]   = (issue_qj_busy && !m_pj[f]) ? cdb_value : issue_vj;
            m_vk[f]   = (issue_qk_busy && !m_pk[f]) ? cdb_value : issue_vk;
        end
        exp_full = 1'b1;
        for (int i = 0; i < DEPTH; i++) if (!m_busy[i]) exp_full = 1'b0;
    endtask

    task automatic set_idle();
        rdy_in = 1'b1; flush_in = 1'b0; issue_valid = 1'b0; cdb_valid = 1'b0;
        issue_op = '0; issue_vj = '0; issue_vk = '0;
        issue_qj_busy = 1'b0; issue_qk_busy = 1'b0;
        issue_qj = '0; issue_qk = '0; issue_dest = '0;
        cdb_tag = '0; cdb_value = '0;
    endtask

    task automatic set_issue(input logic [3:0] op, input logic [31:0] vj, input logic [31:0] vk,
                             input logic pj, input logic [TAG_W-1:0] qj,
                             input logic pk, input logic [TAG_W-1:0] qk, input logic [TAG_W-1:0] dest);
        issue_valid = 1'b1; issue_op = op; issue_vj = vj; issue_vk = vk;
        issue_qj_busy = pj; issue_qj = qj; issue_qk_busy = pk; issue_qk = qk; issue_dest = dest;
    endtask

    task automatic set_cdb(input logic [TAG_W-1:0] tag, input logic [31:0] val);
        cdb_valid = 1'b1; cdb_tag = tag; cdb_value = val;
    endtask

    // One clock: predict, then let the edge happen; returns at the next falling edge.
    task automatic tick();
        model_step();
        @(negedge clk_in);
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            set_idle();
            tick();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rs_full"}, 32'(rs_full), 32'd0);
        chk({tag, "_result_valid"}, 32'(result_valid), 32'd0);
        chk({tag, "_result_tag"}, 32'(result_tag), 32'd0);
        chk({tag, "_result_value"}, result_value, 32'd0);
        chk({tag, "_alu_op1"}, alu_op1, 32'd0);
        chk({tag, "_alu_op2"}, alu_op2, 32'd0);
        chk({tag, "_alu_op"}, 32'(alu_op), 32'd0);
    endtask

    // Monitor: after each edge compare full flag and any result against the scoreboard.
    initial begin
        res_t r;
        forever begin
            @(posedge clk_in);
            #1;
            if (rst_in === 1'b1) begin
                chk("rs_full", 32'(rs_full), 32'(exp_full));
                chk("result_valid", 32'(result_valid), 32'(exp_q.size() > 0));
                if (exp_q.size() > 0) begin
                    r = exp_q.pop_front();
                    if (result_valid) begin
                        chk("result_tag", 32'(result_tag), 32'(r.tag));
                        chk("result_value", result_value, r.val);
                        $display("result t=%0t tag=%0d value=%0h", $time, result_tag, result_value);
                    end
                end
            end
        end
    end

    // Stimulus.
    initial begin
        set_idle();
        rst_in = 1'b0;
        model_reset();
        #2;
        check_reset_outputs("reset");
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;

        // Add 5+7 to tag 3, both ready.
        set_idle(); set_issue(4'd0, 32'd5, 32'd7, 1'b0, '0, 1'b0, '0, 4'd3); tick();
        idle_ticks(4);

        // Sub waiting on tag 2, woken later by the CDB.
        set_idle(); set_issue(4'd1, 32'd0, 32'd1, 1'b1, 4'd2, 1'b0, '0, 4'd4); tick();
        idle_ticks(3);
        set_idle(); set_cdb(4'd2, 32'd10); tick();
        idle_ticks(4);

        // Same, with the CDB broadcast on the issue cycle.
        set_idle(); set_issue(4'd1, 32'd0, 32'd1, 1'b1, 4'd2, 1'b0, '0, 4'd4); set_cdb(4'd2, 32'd10); tick();
        idle_ticks(4);

        // Fill every slot, then a ninth issue that must be dropped.
        for (int i = 0; i < DEPTH + 1; i++) begin
            set_idle(); set_issue(4'd0, 32'd0, 32'(i * 3), 1'b1, 4'd6, 1'b0, '0, 4'(i)); tick();
        end
        idle_ticks(2);
        set_idle(); set_cdb(4'd6, 32'd100); tick();
        idle_ticks(DEPTH + 3);

        // Two entries on tag 5, one broadcast wakes both.
        set_idle(); set_issue(4'd3, 32'd0, 32'h0f0f, 1'b1, 4'd5, 1'b0, '0, 4'd10); tick();
        set_idle(); set_issue(4'd4, 32'd1, 32'd0, 1'b0, '0, 1'b1, 4'd5, 4'd11); tick();
        set_idle(); set_cdb(4'd5, 32'd4); tick();
        idle_ticks(4);

        // Stall with a dispatch in flight.
        set_idle(); set_issue(4'd2, 32'h00f0, 32'h0f00, 1'b0, '0, 1'b0, '0, 4'd7); tick();
        idle_ticks(1);
        for (int i = 0; i < 3; i++) begin set_idle(); rdy_in = 1'b0; tick(); end
        idle_ticks(4);

        // Flush with four waiting entries and one in flight.
        for (int i = 0; i < 4; i++) begin
            set_idle(); set_issue(4'd0, 32'd1, 32'd1, 1'b1, 4'd9, 1'b0, '0, 4'(i + 1)); tick();
        end
        set_idle(); set_issue(4'd6, 32'hffff_fff0, 32'd3, 1'b0, '0, 1'b0, '0, 4'd12); tick();
        idle_ticks(1);
        set_idle(); flush_in = 1'b1; tick();
        set_idle(); set_cdb(4'd9, 32'd55); tick();
        idle_ticks(3);
        set_idle(); set_issue(4'd8, 32'd9, 32'd2, 1'b0, '0, 1'b0, '0, 4'd13); tick();
        idle_ticks(4);

        // Randomised traffic.
        for (int n = 0; n < 600; n++) begin
            set_idle();
            rdy_in   = ($urandom_range(0, 9) != 0);
            flush_in = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 9) < 6)
                set_issue(4'($urandom_range(0, 9)), $urandom, $urandom,
                          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          4'($urandom_range(0, 15)));
            if ($urandom_range(0, 1) == 1)
                set_cdb(4'($urandom_range(0, 15)), $urandom);
            tick();
            if (n == 300) begin
                // Asynchronous reset in the middle of traffic.
                rst_in = 1'b0;
                #1;
                check_reset_outputs("midreset");
                model_reset();
                @(negedge clk_in);
                rst_in = 1'b1;
            end
        end

        idle_ticks(4);
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_rs.md
# alu_rs

Reservation station that feeds the integer ALU in the out-of-order core. Buffers issued ALU micro-ops, captures missing operands from the common data bus (CDB), selects one ready entry per cycle, drives the ALU's `op1`/`op2`/`op` inputs from registers, and returns the ALU result one cycle later as a tagged broadcast for the CDB/ROB.

## Interface
Parameters:
- `DEPTH`, 8: number of entries, a power of two.
- `TAG_W`, 4: ROB tag width.

Ports:
- `clk_in`  in  1  clock; all state changes on the rising edge.
- `rst_in`  in  1  asynchronous, active-low reset.
- `rdy_in`  in  1  global enable; low stalls the block.
- `flush_in`  in  1  misprediction flush, synchronous.
- `issue_valid`  in  1  new micro-op present.
- `issue_op`  in  4  ALU opcode (`Add`, `Sub`, `Or`, `Xor`, `Lshift`, `Rshift`, `Lthan`, `Lequal`, `Rthan`, `Requal`).
- `issue_vj`, `issue_vk`  in  32  operand values, valid when the matching `issue_qj_busy`/`issue_qk_busy` is 0.
- `issue_qj_busy`, `issue_qk_busy`  in  1  operand still pending.
- `issue_qj`, `issue_qk`  in  TAG_W  producer tag of a pending operand.
- `issue_dest`  in  TAG_W  destination ROB tag.
- `rs_full`  out  1  all entries busy; `issue_valid` is ignored while high.
- `cdb_valid`  in  1  CDB broadcast present.
- `cdb_tag`  in  TAG_W  tag on the CDB.
- `cdb_value`  in  32  value on the CDB.
- `alu_op1`, `alu_op2`  out  32  registered ALU operands.
- `alu_op`  out  4  registered ALU opcode.
- `alu_result`  in  32  combinational ALU output.
- `result_valid`  out  1  result broadcast present.
- `result_tag`  out  TAG_W  destination tag of the result.
- `result_value`  out  32  result value.

## Operation
- Each entry holds: busy, op, vj, vk, qj_busy, qj, qk_busy, qk, dest.
- Issue (when `issue_valid` is high, `rs_full` is low and `rdy_in` is high): write to the lowest-index free entry.
  - Same-cycle forwarding: if `cdb_valid` is high and `cdb_tag` matches a pending `issue_qj`/`issue_qk`, the entry stores `cdb_value` for that operand and the operand is marked not pending.
- CDB snoop, every enabled cycle: for every busy entry, a pending operand whose tag equals `cdb_tag` captures `cdb_value` and clears its busy flag. Several entries may capture the same broadcast.
- Ready condition: busy, and both operands not pending, evaluated on registered state only. An entry woken at edge N is first eligible at edge N+1.
- Dispatch: each enabled cycle, the lowest-index ready entry is chosen. On that edge:
  - `alu_op1`/`alu_op2`/`alu_op` are loaded from the entry and its dest is latched into a stage register with a valid bit.
  - The entry is freed.
- Result: on the edge after dispatch, `alu_result` and the latched dest are registered into `result_value`/`result_tag`, and `result_valid` is set to 1. Otherwise `result_valid` is 0.
- The block does not snoop its own result internally. The top level routes `result_*` onto the CDB.
- `rs_full` is the AND of all busy bits, taken from registers.
- Issue and dispatch in the same cycle: both happen. The issue picks a free entry from pre-edge state, so it never lands in the entry being dispatched.
- Stall (`rdy_in` low): no issue, snoop or dispatch. Entries, the dispatch stage and the ALU operand registers hold. `result_valid` is cleared on that edge; a result still pending in the dispatch stage is emitted on the first enabled edge after resume.
- Flush (`flush_in` high with `rdy_in` high): all busy bits, the stage valid bit and `result_valid` are cleared on the edge. A concurrent issue is discarded. A flush outranks every other event.

## Timing
- Reset values, asynchronous while `rst_in` is low: all busy bits 0, stage valid 0.
- Outputs during reset: `rs_full`=0, `result_valid`=0, `result_tag`=0, `result_value`=0, `alu_op1`=0, `alu_op2`=0, `alu_op`=0.
- Latency: issue with both operands ready at edge N → dispatch at N+1 → `result_valid` high after N+2. Three edges from issue to result.
- Wake-up via CDB at edge N → dispatch at N+1 → result after N+2.
- Throughput: one dispatch and one result per enabled cycle.
- Reset asserted mid-operation discards every entry and any in-flight result immediately.

## Test plan
- Reset, then issue `Add` vj=5, vk=7, dest=3, both ready → `result_valid` pulses one cycle with tag 3, value 12, exactly three edges after issue.
- Issue `Sub` with qj_busy=1, qj=2, vk=1 → no dispatch; then CDB tag 2, value 10 → result value 9 two edges later. Repeat with the CDB broadcast on the issue cycle itself → same result one cycle earlier.
- Fill all 8 entries with pending operands → `rs_full`=1 and a ninth issue is dropped; broadcast the tag → entries dispatch in index order 0..7 on consecutive cycles, `rs_full` falls after the first dispatch.
- Two entries wait on the same tag 5 → one CDB broadcast wakes both; results appear on consecutive cycles, lower index first.
- Dispatch in flight, then drop `rdy_in` for 3 cycles → no `result_valid` during the stall; exactly one result after resume, with no duplicate.
- `flush_in` with 4 busy entries and one in flight → `rs_full`=0, no `result_valid` afterwards, and a later issue completes normally.
